// File: rtl/ca_pkg.sv
// ---------------------------------------------------------------------------
// ca_pkg
// Shared definitions for the elementary cellular-automaton row engine.
//   CA_CELLS_DEFAULT  default ring length (cells per displayed row)
//   CA_GEN_W_DEFAULT  default width of the generation counter
//   state_t           engine states: IDLE, ALIGN, COMPUTE
//   rule_lookup()     Wolfram rule evaluation for one (L, C, R) neighbourhood
// ---------------------------------------------------------------------------
package ca_pkg;

    localparam int CA_CELLS_DEFAULT = 160;
    localparam int CA_GEN_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    // The neighbourhood {L,C,R} read as a 3-bit number selects one bit of
    // the rule byte; that bit is the cell's next value.
    function automatic logic rule_lookup(input logic [7:0] rule,
                                         input logic       l,
                                         input logic       c,
                                         input logic       r);
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_row_engine.sv
// ---------------------------------------------------------------------------
// ca_row_engine
// Serial 1-D elementary cellular-automaton row engine. One generation lives
// in a CELLS-bit ring that is rotated one cell at a time: the pixel path
// reads ring[0] while rotating during active video, and during hblank the
// engine rotates the ring once around, replacing each cell with its successor.
//
// Ports
//   clk        pixel clock, all logic on the rising edge
//   reset      asynchronous active-high reset
//   rule       Wolfram rule number, used on every COMPUTE cycle
//   seed_load  reload the single-centre seed and abandon any work in progress
//   step       request computation of the next generation
//   pix_adv    advance the display read by one cell (IDLE only)
//   cell_out   current display cell, ring[0]
//   busy       high while aligning or computing
//   done       one-cycle pulse after the last computed cell
//   gen_count  generations computed since the last seed, wraps
// ---------------------------------------------------------------------------
module ca_row_engine
    import ca_pkg::*;
#(
    parameter int CELLS = CA_CELLS_DEFAULT,
    parameter int GEN_W = CA_GEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rule,
    input  logic             seed_load,
    input  logic             step,
    input  logic             pix_adv,
    output logic             cell_out,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int               PW       = $clog2(CELLS);
    localparam logic [PW-1:0]    LAST_IDX = PW'(CELLS - 1);
    localparam logic [CELLS-1:0] SEED     = {{(CELLS/2 - 1){1'b0}}, 1'b1, {(CELLS/2){1'b0}}};

    state_t           r_state;
    state_t           w_next_state;
    logic [CELLS-1:0] r_ring;
    logic [PW-1:0]    r_pos;
    logic [PW-1:0]    r_idx;
    logic             r_prev;
    logic             r_first0;
    logic             r_done;
    logic [GEN_W-1:0] r_gen;

    logic             w_rotate;
    logic             w_in_bit;
    logic [PW-1:0]    w_pos_next;
    logic             w_last;
    logic             w_left;
    logic             w_right;
    logic             w_new_bit;

    // Rotation offset after one more rotation, wrapping at the ring length
    // (CELLS need not be a power of two).
    assign w_pos_next = (r_pos == LAST_IDX) ? '0 : r_pos + 1'b1;

    assign w_last = (r_state == COMPUTE) && (r_idx == LAST_IDX);

    // Neighbourhood of the cell currently in ring[0]. On the first cycle the
    // left neighbour is still untouched at ring[CELLS-1]; afterwards it has
    // already been overwritten, so the saved old value is used. On the last
    // cycle ring[1] already holds the new cell 0, so the saved old cell 0
    // closes the torus instead.
    assign w_left    = (r_idx == '0) ? r_ring[CELLS-1] : r_prev;
    assign w_right   = (r_idx == LAST_IDX) ? r_first0 : r_ring[1];
    assign w_new_bit = rule_lookup(rule, w_left, r_ring[0], w_right);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and rotation control. A step always wins over pix_adv, and
    // the ring only advances while aligning or computing once busy; seed_load
    // overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_rotate     = 1'b0;
        w_in_bit     = r_ring[0];
        unique case (r_state)
            IDLE: begin
                if (step) begin
                    w_next_state = (r_pos == '0) ? COMPUTE : ALIGN;
                end else if (pix_adv) begin
                    w_rotate = 1'b1;
                end
            end
            ALIGN: begin
                w_rotate = 1'b1;
                if (w_pos_next == '0) begin
                    w_next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                w_rotate = 1'b1;
                w_in_bit = w_new_bit;
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (seed_load) begin
            w_next_state = IDLE;
            w_rotate     = 1'b0;
        end
    end

    // Ring, offset, cell index and generation bookkeeping. done and the
    // generation increment land on the same edge, right after the last cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ring   <= SEED;
            r_pos    <= '0;
            r_idx    <= '0;
            r_prev   <= 1'b0;
            r_first0 <= 1'b0;
            r_done   <= 1'b0;
            r_gen    <= '0;
        end else if (seed_load) begin
            r_ring   <= SEED;
            r_pos    <= '0;
            r_idx    <= '0;
            r_prev   <= 1'b0;
            r_first0 <= 1'b0;
            r_done   <= 1'b0;
            r_gen    <= '0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_gen <= r_gen + 1'b1;
            end
            if (w_rotate) begin
                r_ring <= {w_in_bit, r_ring[CELLS-1:1]};
                r_pos  <= w_pos_next;
            end
            if (r_state == COMPUTE) begin
                r_prev <= r_ring[0];
                if (r_idx == '0) begin
                    r_first0 <= r_ring[0];
                end
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign cell_out  = r_ring[0];
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign gen_count = r_gen;

endmodule

// File: tb/tb_ca_row_engine.sv
// ---------------------------------------------------------------------------
// tb_ca_row_engine
// Self-checking bench for ca_row_engine with a 16-cell ring. Rows are read
// back through cell_out by rotating once around with pix_adv, and compared
// with a toroidal software model of the automaton.
// ---------------------------------------------------------------------------
module tb_ca_row_engine;

    localparam int N = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rule;
    logic        seed_load;
    logic        step;
    logic        pix_adv;
    logic        cell_out;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    int total;
    int bad;

    typedef struct {
        logic [7:0]  rule;
        int          prePix;
        logic [15:0] expRow;
        int          expLat;
        int          expGen;
    } vec_t;

    vec_t vecs[4];

    ca_row_engine #(.CELLS(N), .GEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rule      (rule),
        .seed_load (seed_load),
        .step      (step),
        .pix_adv   (pix_adv),
        .cell_out  (cell_out),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Next generation of a toroidal row under one rule.
    function automatic logic [15:0] nextGen(input logic [15:0] cur, input logic [7:0] rl);
        logic [15:0] nxt;
        for (int k = 0; k < N; k++) begin
            nxt[k] = rl[{cur[(k + N - 1) % N], cur[k], cur[(k + 1) % N]}];
        end
        return nxt;
    endfunction

    // Next generation where cell k is governed by its own rule byte.
    function automatic logic [15:0] nextGenVar(input logic [15:0] cur, input logic [7:0] rr [16]);
        logic [15:0] nxt;
        for (int k = 0; k < N; k++) begin
            nxt[k] = rr[k][{cur[(k + N - 1) % N], cur[k], cur[(k + 1) % N]}];
        end
        return nxt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixAdvance(input int count);
        for (int k = 0; k < count; k++) begin
            pix_adv = 1'b1;
            tick();
            pix_adv = 1'b0;
        end
    endtask

    task automatic seedLoad();
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    // Read a full row through cell_out; leaves the ring back where it started.
    task automatic readRow(output logic [15:0] row);
        row = '0;
        for (int k = 0; k < N; k++) begin
            row[k]  = cell_out;
            pix_adv = 1'b1;
            tick();
            pix_adv = 1'b0;
        end
    endtask

    // Pulse step and count cycles until done (bounded). lat is the cycle,
    // counted from the one after the step edge, in which done is seen.
    task automatic runStep(output int lat, output int busyN);
        step = 1'b1;
        tick();
        step  = 1'b0;
        lat   = 1;
        busyN = 0;
        while (!done && lat < 200) begin
            if (busy) busyN++;
            tick();
            lat++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output int busyN,
                                 output logic [15:0] row);
        rule = v.rule;
        pixAdvance(v.prePix);
        runStep(lat, busyN);
        readRow(row);
    endtask

    initial begin
        logic [15:0] row;
        logic [15:0] modelRow;
        int          modelGen;
        int          lat;
        int          busyN;
        int          pre;
        int          doneCnt;
        logic [7:0]  rr [16];

        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        rule      = 8'd90;
        seed_load = 1'b0;
        step      = 1'b0;
        pix_adv   = 1'b0;

        // Rule 90 from the centre seed; later entries start off-alignment.
        vecs[0] = '{rule: 8'd90, prePix: 0, expRow: 16'h0280, expLat: 17, expGen: 1};
        vecs[1] = '{rule: 8'd90, prePix: 0, expRow: 16'h0440, expLat: 17, expGen: 2};
        vecs[2] = '{rule: 8'd90, prePix: 5, expRow: 16'h0AA0, expLat: 28, expGen: 3};
        vecs[3] = '{rule: 8'd90, prePix: 3, expRow: 16'h1010, expLat: 30, expGen: 4};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and display rotation of the seed.
        checkOutput("rstCell", int'(cell_out), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstGen", int'(gen_count), 0);
        pixAdvance(8);
        checkOutput("seedCentre", int'(cell_out), 1);
        pixAdvance(8);
        checkOutput("seedWrap", int'(cell_out), 0);

        // Table-driven generations.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v], lat, busyN, row);
            checkOutput($sformatf("vec%0dLat", v), lat, vecs[v].expLat);
            checkOutput($sformatf("vec%0dBusy", v), busyN, vecs[v].expLat - 1);
            checkOutput($sformatf("vec%0dRow", v), int'(row), int'(vecs[v].expRow));
            checkOutput($sformatf("vec%0dGen", v), int'(gen_count), vecs[v].expGen);
        end

        // Rule 30 from the centre seed, long enough to wrap around the torus.
        seedLoad();
        modelRow = 16'h0100;
        modelGen = 0;
        checkOutput("reseedGen", int'(gen_count), 0);
        rule = 8'd30;
        for (int g = 0; g < 8; g++) begin
            runStep(lat, busyN);
            modelRow = nextGen(modelRow, 8'd30);
            modelGen++;
            readRow(row);
            checkOutput($sformatf("r30g%0dRow", g), int'(row), int'(modelRow));
            checkOutput($sformatf("r30g%0dBit0", g), int'(row[0]), int'(modelRow[0]));
            checkOutput($sformatf("r30g%0dBit15", g), int'(row[15]), int'(modelRow[15]));
        end
        checkOutput("r30Gen", int'(gen_count), modelGen);

        // Random rules and random display offsets.
        for (int t = 0; t < 12; t++) begin
            rule = 8'($urandom);
            pre  = $urandom_range(0, N - 1);
            pixAdvance(pre);
            runStep(lat, busyN);
            modelRow = nextGen(modelRow, rule);
            modelGen++;
            readRow(row);
            checkOutput($sformatf("rnd%0dLat", t), lat, ((N - pre) % N) + N + 1);
            checkOutput($sformatf("rnd%0dRow", t), int'(row), int'(modelRow));
            checkOutput($sformatf("rnd%0dGen", t), int'(gen_count), modelGen);
        end

        // Rule changing every cycle: each cell follows the rule of its own cycle.
        seedLoad();
        modelRow = 16'h0100;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < N; i++) rr[i] = 8'($urandom);
            step = 1'b1;
            tick();
            step = 1'b0;
            for (int i = 0; i < N; i++) begin
                rule = rr[i];
                tick();
            end
            checkOutput($sformatf("var%0dDone", g), int'(done), 1);
            modelRow = nextGenVar(modelRow, rr);
            readRow(row);
            checkOutput($sformatf("var%0dRow", g), int'(row), int'(modelRow));
        end

        // seed_load in the middle of a computation.
        rule = 8'd90;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        checkOutput("abortBusyBefore", int'(busy), 1);
        seedLoad();
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortGen", int'(gen_count), 0);
        checkOutput("abortDone", int'(done), 0);
        doneCnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) doneCnt++;
            tick();
        end
        checkOutput("abortNoDone", doneCnt, 0);
        readRow(row);
        checkOutput("abortRow", int'(row), 16'h0100);

        // A second step while busy is dropped, not queued.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        step = 1'b1;
        tick();
        step    = 1'b0;
        doneCnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) doneCnt++;
            tick();
        end
        checkOutput("busyStepDones", doneCnt, 1);
        checkOutput("busyStepGen", int'(gen_count), 1);
        readRow(row);
        checkOutput("busyStepRow", int'(row), 16'h0280);

        // Asynchronous reset in the middle of a computation.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstGen", int'(gen_count), 0);
        checkOutput("midRstCell", int'(cell_out), 0);
        tick();
        reset = 1'b0;
        readRow(row);
        checkOutput("midRstRow", int'(row), 16'h0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
